// File: rtl/core_sequencer.sv
// Skiron core multi-cycle sequencer: fetch/decode/execute/memory/writeback control and PC ownership.
// Optional single-step gating of instruction fetch is enabled with `define SEQ_STEP_EN.
module core_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    MEM_TIMEOUT = 255
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [2:0]            OpClass,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  input  logic                  AluDone,
  input  logic                  MemAck,
`ifdef SEQ_STEP_EN
  input  logic                  StepReq,
`endif
  output logic                  MemReq,
  output logic                  MemWe,
  output logic                  MemAddrSel,
  output logic                  InstrLoad,
  output logic                  AluStart,
  output logic                  RegWrite,
  output logic                  Retired,
  output logic [ADDR_WIDTH-1:0] Pc,
  output logic                  Halted,
  output logic                  Fault
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALTED    = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_HALT   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(3'd4);
  localparam logic [15:0]           TMO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [2:0]            state_r;
  logic [2:0]            state_nx_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_nx_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;
  logic [15:0]           tmo_cnt_r;
  logic                  retire_s;
  logic                  retired_r;
  logic                  alu_start_r;
  logic                  reg_write_r;
  logic                  store_r;
  logic                  halted_r;
  logic                  fault_r;
  logic                  step_ok_s;
  logic                  fetch_live_s;
  logic                  req_s;
  logic                  ack_s;
  logic                  tmo_s;

`ifdef SEQ_STEP_EN
  logic step_arm_r;

  // One-deep step latch: armed by any StepReq, consumed when a fetch completes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      step_arm_r <= 1'b0;
    end else begin
      step_arm_r <= StepReq | (step_arm_r & ~(fetch_live_s & MemAck));
    end
  end

  assign step_ok_s = step_arm_r;
`else
  assign step_ok_s = 1'b1;
`endif

  // Requests are gated by Reset_n so an in-flight request drops the instant reset asserts.
  assign fetch_live_s = Reset_n & (state_r == S_FETCH) & step_ok_s;
  assign req_s        = fetch_live_s | (Reset_n & (state_r == S_MEMORY));
  assign ack_s        = req_s & MemAck;
  assign tmo_s        = req_s & ~MemAck & (tmo_cnt_r == TMO_LAST);
  assign pc_inc_s     = pc_r + PC_STEP;

  // Next-state, next-PC and retirement decision.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    retire_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (ack_s) begin
          state_nx_s = S_DECODE;
        end else if (tmo_s) begin
          state_nx_s = S_FAULT;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_DECODE: state_nx_s = S_EXECUTE;
      S_EXECUTE: begin
        if (AluDone) begin
          case (OpClass)
            OP_ALU:            state_nx_s = S_WRITEBACK;
            OP_LOAD, OP_STORE: state_nx_s = S_MEMORY;
            OP_BRANCH: begin
              if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
                state_nx_s = S_FAULT;
              end else begin
                state_nx_s = S_FETCH;
                retire_s   = 1'b1;
                pc_nx_s    = BranchTaken ? BranchTarget : pc_inc_s;
              end
            end
            OP_HALT: state_nx_s = S_HALTED;
            default: state_nx_s = S_FAULT;
          endcase
        end else begin
          state_nx_s = S_EXECUTE;
        end
      end
      S_MEMORY: begin
        if (ack_s) begin
          if (store_r) begin
            state_nx_s = S_FETCH;
            retire_s   = 1'b1;
            pc_nx_s    = pc_inc_s;
          end else begin
            state_nx_s = S_WRITEBACK;
          end
        end else if (tmo_s) begin
          state_nx_s = S_FAULT;
        end else begin
          state_nx_s = S_MEMORY;
        end
      end
      S_WRITEBACK: begin
        state_nx_s = S_FETCH;
        retire_s   = 1'b1;
        pc_nx_s    = pc_inc_s;
      end
      S_HALTED: state_nx_s = S_HALTED;
      S_FAULT:  state_nx_s = S_FAULT;
      default:  state_nx_s = S_FAULT;
    endcase
  end

  // State, PC, timeout counter and registered strobes/status.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= S_FETCH;
      pc_r        <= RESET_PC;
      tmo_cnt_r   <= 16'd0;
      retired_r   <= 1'b0;
      alu_start_r <= 1'b0;
      reg_write_r <= 1'b0;
      store_r     <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      retired_r   <= retire_s;
      alu_start_r <= (state_nx_s == S_EXECUTE) && (state_r != S_EXECUTE);
      reg_write_r <= (state_nx_s == S_WRITEBACK);
      halted_r    <= (state_nx_s == S_HALTED);
      fault_r     <= (state_nx_s == S_FAULT);
      if ((state_r == S_EXECUTE) && (state_nx_s == S_MEMORY)) begin
        store_r <= (OpClass == OP_STORE);
      end
      // Any state change restarts the wait count, so each new request gets a full budget.
      if (state_nx_s != state_r) begin
        tmo_cnt_r <= 16'd0;
      end else if (req_s && !MemAck) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
    end
  end

  assign MemReq     = req_s;
  assign MemWe      = Reset_n & (state_r == S_MEMORY) & store_r;
  assign MemAddrSel = (state_r == S_MEMORY);
  assign InstrLoad  = fetch_live_s & MemAck;
  assign AluStart   = alu_start_r;
  assign RegWrite   = reg_write_r;
  assign Retired    = retired_r;
  assign Pc         = pc_r;
  assign Halted     = halted_r;
  assign Fault      = fault_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios plus randomized instruction streams
// compared against an instruction-level timeline model of the sequencer.
module tb_core_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          TMO = 8;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [2:0]  OpClass = 3'd0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        AluDone = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemReq, MemWe, MemAddrSel, InstrLoad, AluStart, RegWrite, Retired, Halted, Fault;
  logic [31:0] Pc;
`ifdef SEQ_STEP_EN
  logic        StepReq = 1'b1;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc = RPC;
  logic        retire_pend = 1'b0;
  int          term_kind = 0;  // 0 running, 1 halted, 2 faulted

  core_sequencer #(.ADDR_WIDTH(32), .RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .OpClass(OpClass), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .AluDone(AluDone), .MemAck(MemAck),
`ifdef SEQ_STEP_EN
    .StepReq(StepReq),
`endif
    .MemReq(MemReq), .MemWe(MemWe), .MemAddrSel(MemAddrSel), .InstrLoad(InstrLoad),
    .AluStart(AluStart), .RegWrite(RegWrite), .Retired(Retired), .Pc(Pc),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    MemAck  = 1'($urandom);
    #1;
    chk1("rst_memreq", MemReq, 1'b0);
    chkw("rst_pc", Pc, RPC);
    chk1("rst_halted", Halted, 1'b0);
    chk1("rst_fault", Fault, 1'b0);
    chk1("rst_regwrite", RegWrite, 1'b0);
    chk1("rst_retired", Retired, 1'b0);
    chk1("rst_alustart", AluStart, 1'b0);
    chk1("rst_instrload", InstrLoad, 1'b0);
    tick();
    Reset_n = 1'b1;
    MemAck  = 1'b0;
    #1;
    chk1("rel_memreq", MemReq, 1'b1);
    exp_pc      = RPC;
    retire_pend = 1'b0;
    term_kind   = 0;
  endtask

  task automatic writeback();
    MemAck = 1'($urandom);
    #1;
    chk1("wb_regwrite", RegWrite, 1'b1);
    chk1("wb_memreq", MemReq, 1'b0);
    chkw("wb_pc", Pc, exp_pc);
    tick();
    exp_pc      = exp_pc + 32'd4;
    retire_pend = 1'b1;
  endtask

  // One instruction; a delay of 8 means the ack never comes (timeout).
  task automatic run_instr(input logic [2:0] cls, input int fd, input int ad, input int md,
                           input logic taken, input logic [31:0] target);
    int   nf;
    int   nm;
    logic ack_e;
    nf = (fd > 7) ? 8 : fd + 1;
    for (int i = 0; i < nf; i++) begin
      ack_e   = (fd < 8) && (i == fd);
      MemAck  = ack_e;
      AluDone = 1'($urandom);
      OpClass = 3'($urandom);
      #1;
      chk1("fetch_memreq", MemReq, 1'b1);
      chk1("fetch_sel", MemAddrSel, 1'b0);
      chk1("fetch_we", MemWe, 1'b0);
      chk1("fetch_instrload", InstrLoad, ack_e);
      chk1("fetch_retired", Retired, (i == 0) && retire_pend);
      chkw("fetch_pc", Pc, exp_pc);
      chk1("fetch_alustart", AluStart, 1'b0);
      chk1("fetch_fault", Fault, 1'b0);
      tick();
    end
    retire_pend = 1'b0;
    if (fd > 7) begin
      term_kind = 2;
      return;
    end
    MemAck  = 1'($urandom);
    OpClass = cls;
    AluDone = 1'($urandom);
    #1;
    chk1("dec_memreq", MemReq, 1'b0);
    chk1("dec_instrload", InstrLoad, 1'b0);
    chk1("dec_alustart", AluStart, 1'b0);
    tick();
    for (int j = 0; j <= ad; j++) begin
      AluDone      = (j == ad);
      MemAck       = 1'($urandom);
      OpClass      = cls;
      BranchTaken  = taken;
      BranchTarget = target;
      #1;
      chk1("ex_alustart", AluStart, (j == 0));
      chk1("ex_memreq", MemReq, 1'b0);
      chk1("ex_regwrite", RegWrite, 1'b0);
      chk1("ex_retired", Retired, 1'b0);
      tick();
    end
    case (cls)
      3'd0: writeback();
      3'd1, 3'd2: begin
        nm = (md > 7) ? 8 : md + 1;
        for (int k = 0; k < nm; k++) begin
          MemAck = (md < 8) && (k == md);
          #1;
          chk1("mem_memreq", MemReq, 1'b1);
          chk1("mem_sel", MemAddrSel, 1'b1);
          chk1("mem_we", MemWe, (cls == 3'd2));
          chk1("mem_instrload", InstrLoad, 1'b0);
          chk1("mem_regwrite", RegWrite, 1'b0);
          tick();
        end
        if (md > 7) begin
          term_kind = 2;
        end else if (cls == 3'd1) begin
          writeback();
        end else begin
          exp_pc      = exp_pc + 32'd4;
          retire_pend = 1'b1;
        end
      end
      3'd3: begin
        if (taken && (target[1:0] != 2'b00)) begin
          term_kind = 2;
        end else begin
          exp_pc      = taken ? target : exp_pc + 32'd4;
          retire_pend = 1'b1;
        end
      end
      3'd4:    term_kind = 1;
      default: term_kind = 2;
    endcase
  endtask

  task automatic check_terminal();
    for (int c = 0; c < 4; c++) begin
      MemAck  = 1'($urandom);
      AluDone = 1'($urandom);
      OpClass = 3'($urandom);
      #1;
      chk1("term_halted", Halted, (term_kind == 1));
      chk1("term_fault", Fault, (term_kind == 2));
      chk1("term_memreq", MemReq, 1'b0);
      chk1("term_instrload", InstrLoad, 1'b0);
      chk1("term_retired", Retired, 1'b0);
      chk1("term_regwrite", RegWrite, 1'b0);
      chk1("term_alustart", AluStart, 1'b0);
      chkw("term_pc", Pc, exp_pc);
      tick();
    end
  endtask

  initial begin
    logic [2:0]  cls;
    logic [31:0] tgt;
    logic        tk;
    int          r, fd, ad, md;

    @(negedge Clock);
    do_reset();

    // Directed: ALU, delayed LOAD, taken branch, PC wrap, STORE.
    run_instr(3'd0, 0, 0, 0, 1'b0, 32'd0);
    run_instr(3'd1, 0, 0, 3, 1'b0, 32'd0);
    run_instr(3'd3, 0, 0, 0, 1'b1, 32'h0000_0200);
    run_instr(3'd3, 0, 0, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(3'd0, 0, 0, 0, 1'b0, 32'd0);
    chkw("pc_wrap", Pc, 32'd0);
    run_instr(3'd3, 1, 2, 0, 1'b0, 32'h0000_0203);
    run_instr(3'd2, 0, 0, 0, 1'b0, 32'd0);
    run_instr(3'd3, 0, 0, 0, 1'b1, 32'h0000_0202);
    check_terminal();
    do_reset();

    // Fetch timeout, ack on the last allowed cycle, memory timeout.
    run_instr(3'd0, 8, 0, 0, 1'b0, 32'd0);
    check_terminal();
    do_reset();
    run_instr(3'd0, 7, 0, 0, 1'b0, 32'd0);
    run_instr(3'd2, 0, 0, 7, 1'b0, 32'd0);
    run_instr(3'd1, 0, 0, 8, 1'b0, 32'd0);
    check_terminal();
    do_reset();
    run_instr(3'd4, 0, 1, 0, 1'b0, 32'd0);
    check_terminal();
    do_reset();
    run_instr(3'd6, 0, 0, 0, 1'b0, 32'd0);
    check_terminal();
    do_reset();

    // Reset asserted while a LOAD waits in MEMORY.
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    tick();
    OpClass = 3'd1;
    AluDone = 1'b1;
    tick();
    MemAck = 1'b0;
    #1;
    chk1("midmem_req", MemReq, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk1("midmem_drop", MemReq, 1'b0);
    chkw("midmem_pc", Pc, RPC);
    MemAck = 1'b1;
    tick();
    do_reset();
    run_instr(3'd0, 0, 0, 0, 1'b0, 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      r   = int'($urandom_range(0, 19));
      fd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      ad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
      md  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      tk  = 1'($urandom);
      tgt = $urandom;
      if (tk) tgt = tgt & 32'hFFFF_FFFC;
      if (r < 4)       cls = 3'd0;
      else if (r < 8)  cls = 3'd1;
      else if (r < 12) cls = 3'd2;
      else if (r < 18) cls = 3'd3;
      else if (r == 18) begin
        cls = 3'($urandom_range(3, 7));
        if (cls == 3'd3) begin
          tk  = 1'b1;
          tgt = tgt | 32'd1;
        end
      end else begin
        cls = 3'($urandom_range(1, 2));
        if ($urandom_range(0, 1) == 0) fd = 8;
        else md = 8;
      end
      run_instr(cls, fd, ad, md, tk, tgt);
      if (term_kind != 0) begin
        check_terminal();
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
